// File: rtl/rf_scoreboard_if.sv
// Register-file bus: read ports, two write-back ports, issue/flush strobes
// and the busy scoreboard outputs.
interface rf_scoreboard_if #(
  parameter int WIDTH   = 32,
  parameter int ADDRNUM = 5,
  parameter int NRD     = 2
);
  logic [NRD*ADDRNUM-1:0] ra;
  logic [NRD*WIDTH-1:0]   rd;
  logic [NRD-1:0]         rbusy;
  logic                   we0;
  logic [ADDRNUM-1:0]     wa0;
  logic [WIDTH-1:0]       wd0;
  logic                   we1;
  logic [ADDRNUM-1:0]     wa1;
  logic [WIDTH-1:0]       wd1;
  logic                   iss_valid;
  logic [ADDRNUM-1:0]     iss_addr;
  logic                   flush;
  logic [ADDRNUM:0]       busy_cnt;

  modport master (
    output ra, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_addr, flush,
    input  rd, rbusy, busy_cnt
  );

  modport slave (
    input  ra, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_addr, flush,
    output rd, rbusy, busy_cnt
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Multi-read, dual-write-back register file with a per-register busy
// scoreboard for hazard detection; write-first bypass on every read port.
module rf_scoreboard #(
  parameter int          WIDTH   = 32,
  parameter int          ADDRNUM = 5,
  parameter int          REGNUM  = 32,
  parameter int          NRD     = 2,
  parameter logic [31:0] SP_INIT = 32'h2ffc,
  parameter logic [31:0] GP_INIT = 32'h1800
) (
  input logic            clk,
  input logic            rstn,
  rf_scoreboard_if.slave rf
);

  logic [WIDTH-1:0]  regs [REGNUM];
  logic [REGNUM-1:0] busy;
  logic [REGNUM-1:0] busy_nxt;
  logic [ADDRNUM:0]  cnt_q;
  logic [ADDRNUM:0]  cnt_nxt;

  // Both ports assign in order so port 1 wins a same-address collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < REGNUM; i++) begin
        if (i == 2)
          regs[ADDRNUM'(i)] <= WIDTH'(SP_INIT);
        else if (i == 3)
          regs[ADDRNUM'(i)] <= WIDTH'(GP_INIT);
        else
          regs[ADDRNUM'(i)] <= '0;
      end
    end else begin
      if (rf.we0 && rf.wa0 != '0)
        regs[rf.wa0] <= rf.wd0;
      if (rf.we1 && rf.wa1 != '0)
        regs[rf.wa1] <= rf.wd1;
    end
  end

  // Priority: flush, then issue (younger producer), then write-back clear.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned r = 1; r < REGNUM; r++) begin
      if (rf.flush)
        busy_nxt[ADDRNUM'(r)] = 1'b0;
      else if (rf.iss_valid && rf.iss_addr == ADDRNUM'(r))
        busy_nxt[ADDRNUM'(r)] = 1'b1;
      else if ((rf.we0 && rf.wa0 == ADDRNUM'(r)) ||
               (rf.we1 && rf.wa1 == ADDRNUM'(r)))
        busy_nxt[ADDRNUM'(r)] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < REGNUM; i++)
      cnt_nxt = cnt_nxt + (ADDRNUM+1)'(busy_nxt[ADDRNUM'(i)]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign rf.busy_cnt = cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDRNUM-1:0] a;
    logic               hit0;
    logic               hit1;

    assign a    = rf.ra[k*ADDRNUM +: ADDRNUM];
    assign hit1 = rf.we1 && rf.wa1 == a && a != '0;
    assign hit0 = rf.we0 && rf.wa0 == a && a != '0;

    assign rf.rd[k*WIDTH +: WIDTH] = hit1 ? rf.wd1 : hit0 ? rf.wd0 : regs[a];
    // A same-cycle write-back already forwards the data, so hide the busy flag.
    assign rf.rbusy[k] = busy[a] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard.
module tb_rf_scoreboard;

  logic clk;
  logic rstn;
  int   nvec;
  int   nerr;

  rf_scoreboard_if #(.WIDTH(32), .ADDRNUM(5), .NRD(2)) bus ();

  rf_scoreboard #(
    .WIDTH  (32),
    .ADDRNUM(5),
    .REGNUM (32),
    .NRD    (2),
    .SP_INIT(32'h2ffc),
    .GP_INIT(32'h1800)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .rf  (bus)
  );

  logic [31:0] rd0;
  logic [31:0] rd1;
  assign rd0 = bus.rd[31:0];
  assign rd1 = bus.rd[63:32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
    bus.iss_valid = 1'b0; bus.iss_addr = '0;
    bus.flush = 1'b0;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    bus.ra = {a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    set_ra(5'd2, 5'd3);
    step();
    step();
    rstn = 1'b1;
    #1;
    nvec++; if (rd0 !== 32'h2ffc) begin nerr++; $display("FAIL reset_sp got %h exp %h", rd0, 32'h2ffc); end
    nvec++; if (rd1 !== 32'h1800) begin nerr++; $display("FAIL reset_gp got %h exp %h", rd1, 32'h1800); end
    nvec++; if (bus.rbusy !== 2'b00) begin nerr++; $display("FAIL reset_rbusy got %b exp 00", bus.rbusy); end
    nvec++; if (bus.busy_cnt !== 6'd0) begin nerr++; $display("FAIL reset_cnt got %0d exp 0", bus.busy_cnt); end
    set_ra(5'd0, 5'd3);
    bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'd5;
    #1;
    nvec++; if (rd0 !== 32'd0) begin nerr++; $display("FAIL r0_bypass got %h exp 0", rd0); end
    step();
    idle();
    #1;
    nvec++; if (rd0 !== 32'd0) begin nerr++; $display("FAIL r0_store got %h exp 0", rd0); end
  endtask

  task automatic test_collision();
    set_ra(5'd7, 5'd0);
    bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'hAAAA;
    bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'hBBBB;
    #1;
    nvec++; if (rd0 !== 32'hBBBB) begin nerr++; $display("FAIL coll_bypass got %h exp %h", rd0, 32'hBBBB); end
    step();
    idle();
    #1;
    nvec++; if (rd0 !== 32'hBBBB) begin nerr++; $display("FAIL coll_store got %h exp %h", rd0, 32'hBBBB); end
    set_ra(5'd7, 5'd9);
    nvec++; if (rd1 !== 32'd0) begin nerr++; $display("FAIL r9_before got %h exp 0", rd1); end
    bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h1234;
    #1;
    nvec++; if (rd1 !== 32'h1234) begin nerr++; $display("FAIL w0_bypass got %h exp %h", rd1, 32'h1234); end
    step();
    idle();
    #1;
    nvec++; if (rd1 !== 32'h1234) begin nerr++; $display("FAIL w0_store got %h exp %h", rd1, 32'h1234); end
  endtask

  task automatic test_issue_wb();
    set_ra(5'd5, 5'd0);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd5;
    #1;
    nvec++; if (bus.rbusy[0] !== 1'b0) begin nerr++; $display("FAIL iss_same_cycle got %b exp 0", bus.rbusy[0]); end
    step();
    idle();
    #1;
    nvec++; if (bus.rbusy[0] !== 1'b1) begin nerr++; $display("FAIL iss_rbusy got %b exp 1", bus.rbusy[0]); end
    nvec++; if (bus.busy_cnt !== 6'd1) begin nerr++; $display("FAIL iss_cnt got %0d exp 1", bus.busy_cnt); end
    bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'h55;
    #1;
    nvec++; if (bus.rbusy[0] !== 1'b0) begin nerr++; $display("FAIL wb_mask got %b exp 0", bus.rbusy[0]); end
    nvec++; if (rd0 !== 32'h55) begin nerr++; $display("FAIL wb_bypass got %h exp %h", rd0, 32'h55); end
    step();
    idle();
    #1;
    nvec++; if (bus.busy_cnt !== 6'd0) begin nerr++; $display("FAIL wb_cnt got %0d exp 0", bus.busy_cnt); end
    nvec++; if (bus.rbusy[0] !== 1'b0) begin nerr++; $display("FAIL wb_rbusy got %b exp 0", bus.rbusy[0]); end
    nvec++; if (rd0 !== 32'h55) begin nerr++; $display("FAIL wb_store got %h exp %h", rd0, 32'h55); end
  endtask

  task automatic test_issue_vs_wb();
    set_ra(5'd0, 5'd6);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd6;
    bus.we1 = 1'b1; bus.wa1 = 5'd6; bus.wd1 = 32'h66;
    #1;
    nvec++; if (bus.rbusy[1] !== 1'b0) begin nerr++; $display("FAIL ivw_edge got %b exp 0", bus.rbusy[1]); end
    step();
    idle();
    #1;
    nvec++; if (bus.rbusy[1] !== 1'b1) begin nerr++; $display("FAIL ivw_after got %b exp 1", bus.rbusy[1]); end
    nvec++; if (bus.busy_cnt !== 6'd1) begin nerr++; $display("FAIL ivw_cnt got %0d exp 1", bus.busy_cnt); end
    nvec++; if (rd1 !== 32'h66) begin nerr++; $display("FAIL ivw_data got %h exp %h", rd1, 32'h66); end
    bus.we0 = 1'b1; bus.wa0 = 5'd6; bus.wd0 = 32'h67;
    step();
    idle();
    #1;
    nvec++; if (bus.busy_cnt !== 6'd0) begin nerr++; $display("FAIL ivw_clear got %0d exp 0", bus.busy_cnt); end
  endtask

  task automatic test_flush();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
    step();
    bus.iss_addr = 5'd8;
    step();
    bus.iss_addr = 5'd12;
    step();
    idle();
    #1;
    nvec++; if (bus.busy_cnt !== 6'd3) begin nerr++; $display("FAIL fl_cnt3 got %0d exp 3", bus.busy_cnt); end
    // reissue of a busy register leaves the count alone
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
    step();
    idle();
    #1;
    nvec++; if (bus.busy_cnt !== 6'd3) begin nerr++; $display("FAIL fl_reissue got %0d exp 3", bus.busy_cnt); end
    set_ra(5'd4, 5'd13);
    bus.flush = 1'b1;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd13;
    bus.we0 = 1'b1; bus.wa0 = 5'd8; bus.wd0 = 32'h88;
    #1;
    nvec++; if (bus.rbusy[0] !== 1'b1) begin nerr++; $display("FAIL fl_nomask got %b exp 1", bus.rbusy[0]); end
    step();
    idle();
    #1;
    nvec++; if (bus.busy_cnt !== 6'd0) begin nerr++; $display("FAIL fl_cnt0 got %0d exp 0", bus.busy_cnt); end
    nvec++; if (bus.rbusy !== 2'b00) begin nerr++; $display("FAIL fl_rbusy got %b exp 00", bus.rbusy); end
    set_ra(5'd8, 5'd13);
    #1;
    nvec++; if (rd0 !== 32'h88) begin nerr++; $display("FAIL fl_data got %h exp %h", rd0, 32'h88); end
  endtask

  task automatic test_async_reset();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd10;
    step();
    bus.iss_addr = 5'd11;
    step();
    idle();
    set_ra(5'd9, 5'd10);
    #1;
    nvec++; if (bus.busy_cnt !== 6'd2) begin nerr++; $display("FAIL ar_cnt2 got %0d exp 2", bus.busy_cnt); end
    nvec++; if (bus.rbusy[1] !== 1'b1) begin nerr++; $display("FAIL ar_busy10 got %b exp 1", bus.rbusy[1]); end
    nvec++; if (rd0 !== 32'h1234) begin nerr++; $display("FAIL ar_r9 got %h exp %h", rd0, 32'h1234); end
    bus.we0 = 1'b1; bus.wa0 = 5'd2; bus.wd0 = 32'hDEAD;
    #1;
    rstn = 1'b0;
    #1;
    nvec++; if (bus.busy_cnt !== 6'd0) begin nerr++; $display("FAIL ar_cnt got %0d exp 0", bus.busy_cnt); end
    nvec++; if (bus.rbusy[1] !== 1'b0) begin nerr++; $display("FAIL ar_rbusy got %b exp 0", bus.rbusy[1]); end
    nvec++; if (rd0 !== 32'd0) begin nerr++; $display("FAIL ar_r9_clr got %h exp 0", rd0); end
    step();
    idle();
    rstn = 1'b1;
    set_ra(5'd2, 5'd3);
    #1;
    nvec++; if (rd0 !== 32'h2ffc) begin nerr++; $display("FAIL ar_lost_write got %h exp %h", rd0, 32'h2ffc); end
    nvec++; if (bus.busy_cnt !== 6'd0) begin nerr++; $display("FAIL ar_cnt_post got %0d exp 0", bus.busy_cnt); end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rstn = 1'b0;
    idle();
    set_ra(5'd0, 5'd0);
    test_reset();
    test_collision();
    test_issue_wb();
    test_issue_vs_wb();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
